dm_lut_prog: RTL and testbench
==============================

DM_LUT_PROG -- requirements
Module: dm_lut_prog

Interface
REQ-001 Parameter PW, default 5: pointer width.
REQ-002 Parameter DEPTH, default 32: table entries, 1 <= DEPTH <= 2^PW.
REQ-003 Parameter AW, default 8: data memory address width.
REQ-004 Parameter SW, default 4: signed post-modify step width.
REQ-005 Port Clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 Port Reset  input  1  synchronous, active-high reset.
REQ-007 Port ptr  input  PW  read/post-modify entry select.
REQ-008 Port rd_en  input  1  read request.
REQ-009 Port step_en  input  1  post-modify the read entry; qualified by rd_en.
REQ-010 Port step  input  SW  signed two's-complement post-modify amount.
REQ-011 Port wr_en  input  1  program request.
REQ-012 Port wr_ptr  input  PW  program entry select.
REQ-013 Port wr_data  input  AW  program value.
REQ-014 Port restore  input  1  single-cycle pulse that starts a reload of the default table.
REQ-015 Port dm_adr  output  AW  registered lookup result.
REQ-016 Port dm_vld  output  1  dm_adr holds a valid lookup result this cycle.
REQ-017 Port busy  output  1  restore in progress.

Function
REQ-018 Table holds DEPTH registered entries, each AW bits.
REQ-019 Default entries: 0 = -11, 1 = 9, 2 = -20, 3 = 14, 4 = 3, 5 = 17, each sign-extended or truncated to AW bits; all other entries are all-ones.
REQ-020 Read latency is 1 cycle: rd_en high in cycle N drives dm_vld high in N+1, with dm_adr = entry[ptr] as sampled at the edge ending cycle N.
REQ-021 When rd_en is low in cycle N, dm_vld is low in N+1 and dm_adr holds its previous value.
REQ-022 ptr >= DEPTH with rd_en high: dm_adr = all-ones, dm_vld = 1, no table change.
REQ-023 rd_en and step_en both high: the old value is returned, and entry[ptr] <= entry[ptr] + sign-extended step, modulo 2^AW (wrap, no saturation).
REQ-024 step_en with rd_en low has no effect.
REQ-025 wr_en high with wr_ptr < DEPTH: entry[wr_ptr] <= wr_data; wr_ptr >= DEPTH is ignored.
REQ-026 Read and write to the same entry in the same cycle: the read returns the old value (read-before-write).
REQ-027 Write and post-modify to the same entry in the same cycle: the write wins and the step is discarded.
REQ-028 Back-to-back post-modify reads of one entry: each read sees the previous cycle's update.
REQ-029 FSM states IDLE and RESTORE; reset state is IDLE.
REQ-030 IDLE -> RESTORE when restore = 1; the restore counter is loaded with 0.
REQ-031 In RESTORE, one entry per cycle, at the counter index, is reloaded with its default value and the counter increments.
REQ-032 RESTORE -> IDLE after entry DEPTH-1 is reloaded; busy = 1 for exactly DEPTH cycles.
REQ-033 busy = 1 in RESTORE only.
REQ-034 While busy: rd_en, step_en and wr_en are ignored, dm_vld = 0 on the following cycle, and a further restore pulse is ignored.
REQ-035 restore and wr_en asserted in the same IDLE cycle: the write is discarded and the restore starts.

Reset
REQ-036 Reset = 1 at an edge: all entries take their defaults, the FSM enters IDLE, and the counter clears to 0.
REQ-037 Outputs after that edge: dm_adr = all-ones, dm_vld = 0, busy = 0.
REQ-038 Reset overrides every other input, including during RESTORE; the restore is abandoned and the table is fully reloaded.

Verification
REQ-039 After Reset, rd_en = 1 with ptr = 0, 1, 2, 5, 6 on consecutive cycles -> dm_adr = 0xF5, 0x09, 0xEC, 0x11, 0xFF, one cycle later each, with dm_vld = 1.
REQ-040 ptr = 4, step = +1, rd_en = step_en = 1 for 3 cycles -> dm_adr = 3, 4, 5; the next plain read returns 6.
REQ-041 Write entry 7 = 0xFE, then step +3 on entry 7 -> read returns 0xFE; the following read returns 0x01 (wrap-around).
REQ-042 Same cycle: wr_en (entry 3 = 0x40) with rd_en + step_en on ptr 3, step = -2 -> dm_adr = 14; the next read returns 0x40 (write wins).
REQ-043 Write entry 0 = 0x55, then pulse restore -> busy = 1 for 32 cycles and reads during busy give dm_vld = 0; afterwards entry 0 reads 0xF5.
REQ-044 Reset asserted at cycle 10 of a restore -> busy = 0 and dm_vld = 0 next cycle, and all entries read their default values.

Source files
------------

// File: rtl/dm_lut_prog_if.sv
// dm_lut_prog_if: lookup, post-modify, program and restore signals of the address table
interface dm_lut_prog_if #(
    parameter int PW = 5,
    parameter int AW = 8,
    parameter int SW = 4
);
    logic [PW-1:0] ptr;
    logic          rd_en;
    logic          step_en;
    logic [SW-1:0] step;
    logic          wr_en;
    logic [PW-1:0] wr_ptr;
    logic [AW-1:0] wr_data;
    logic          restore;
    logic [AW-1:0] dm_adr;
    logic          dm_vld;
    logic          busy;

    modport master (
        output ptr, rd_en, step_en, step, wr_en, wr_ptr, wr_data, restore,
        input  dm_adr, dm_vld, busy
    );

    modport slave (
        input  ptr, rd_en, step_en, step, wr_en, wr_ptr, wr_data, restore,
        output dm_adr, dm_vld, busy
    );
endinterface

// File: rtl/dm_lut_prog.sv
// dm_lut_prog: programmable data-memory address table with post-modify reads and default restore
module dm_lut_prog #(
    parameter int PW    = 5,
    parameter int DEPTH = 32,
    parameter int AW    = 8,
    parameter int SW    = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    dm_lut_prog_if.slave bus
);
    typedef enum logic {IDLE, RESTORE} state_t;

    state_t        state_q;
    logic [PW-1:0] cnt_q;
    logic [AW-1:0] table_q [DEPTH];
    logic [AW-1:0] table_d [DEPTH];
    logic [AW-1:0] dm_adr_q;
    logic [AW-1:0] dm_adr_d;
    logic          dm_vld_q;
    logic          rd_rng;
    logic          wr_rng;

    function automatic logic [AW-1:0] def_val(input int i);
        return i == 0 ? AW'(-11) :
               i == 1 ? AW'(9)   :
               i == 2 ? AW'(-20) :
               i == 3 ? AW'(14)  :
               i == 4 ? AW'(3)   :
               i == 5 ? AW'(17)  : '1;
    endfunction

    assign rd_rng     = 32'(bus.ptr) < DEPTH;
    assign wr_rng     = 32'(bus.wr_ptr) < DEPTH;
    assign dm_adr_d   = bus.rd_en ? (rd_rng ? table_q[bus.ptr] : '1) : dm_adr_q;
    assign bus.dm_adr = dm_adr_q;
    assign bus.dm_vld = dm_vld_q;
    assign bus.busy   = state_q == RESTORE;

    // Next table contents: restore reload, else post-modify with the program write taking priority
    always_comb begin
        table_d = table_q;
        if (state_q == RESTORE) begin
            table_d[cnt_q] = def_val(int'(cnt_q));
        end else if (!bus.restore) begin
            if (bus.rd_en && bus.step_en && rd_rng)
                table_d[bus.ptr] = table_q[bus.ptr] + AW'($signed(bus.step));
            if (bus.wr_en && wr_rng)
                table_d[bus.wr_ptr] = bus.wr_data;
        end
    end

    // Restore FSM plus table and registered lookup output; reset reloads everything at once
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dm_adr_q <= '1;
            dm_vld_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) table_q[i] <= def_val(i);
        end else begin
            table_q <= table_d;
            if (state_q == RESTORE) begin
                dm_vld_q <= 1'b0;
                cnt_q    <= cnt_q + 1'b1;
                if (cnt_q == PW'(DEPTH - 1)) state_q <= IDLE;
            end else begin
                dm_vld_q <= bus.rd_en;
                dm_adr_q <= dm_adr_d;
                if (bus.restore) begin
                    state_q <= RESTORE;
                    cnt_q   <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_lut_prog.sv
// tb_dm_lut_prog: randomized and directed scoreboard bench for dm_lut_prog
module tb_dm_lut_prog;
    localparam int N = 32;

    typedef struct {
        int         due;
        logic       vld;
        logic [7:0] adr;
        logic       chk_adr;
        logic       busy;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    exp_t q[$];

    logic [7:0] mdl [N];
    int         m_rem;

    dm_lut_prog_if #(.PW(5), .AW(8), .SW(4)) bus ();

    dm_lut_prog #(.PW(5), .DEPTH(N), .AW(8), .SW(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [7:0] dflt(input int i);
        logic [7:0] t [6] = '{8'hF5, 8'h09, 8'hEC, 8'h0E, 8'h03, 8'h11};
        return i < 6 ? t[i] : 8'hFF;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, req);
    endtask

    always @(negedge Clk) begin
        if (q.size() != 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("dm_vld", 8'(bus.dm_vld), 8'(e.vld));
            chk("busy", 8'(bus.busy), 8'(e.busy));
            if (e.vld || e.chk_adr) chk("dm_adr", bus.dm_adr, e.adr);
        end
    end

    task automatic step_cycle(input bit r, input logic [4:0] p, input bit rd, input bit st,
                              input logic [3:0] s, input bit wr, input logic [4:0] wp,
                              input logic [7:0] wd, input bit rs);
        exp_t e;
        int   sv;
        @(posedge Clk);
        #1;
        Reset = r; bus.ptr = p; bus.rd_en = rd; bus.step_en = st; bus.step = s;
        bus.wr_en = wr; bus.wr_ptr = wp; bus.wr_data = wd; bus.restore = rs;
        e = '{due: cyc + 1, vld: 1'b0, adr: 8'hFF, chk_adr: 1'b0, busy: 1'b0};
        if (r) begin
            for (int i = 0; i < N; i++) mdl[i] = dflt(i);
            m_rem = 0;
            e.chk_adr = 1'b1;
        end else if (m_rem > 0) begin
            mdl[N - m_rem] = dflt(N - m_rem);
            m_rem--;
            e.busy = m_rem > 0;
        end else begin
            e.vld = rd;
            e.adr = mdl[p];
            if (rs) begin
                m_rem  = N;
                e.busy = 1'b1;
            end else begin
                sv = s >= 8 ? int'(s) - 16 : int'(s);
                if (rd && st) mdl[p] = 8'(int'(mdl[p]) + sv);
                if (wr) mdl[wp] = wd;
            end
        end
        q.push_back(e);
    endtask

    task automatic rd_c(input logic [4:0] p);
        step_cycle(0, p, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Reset = 1'b1;
        bus.ptr = '0; bus.rd_en = 0; bus.step_en = 0; bus.step = '0;
        bus.wr_en = 0; bus.wr_ptr = '0; bus.wr_data = '0; bus.restore = 0;
        step_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        foreach (mdl[i]) if (i < 6) rd_c(5'(i));
        rd_c(6);
        repeat (3) step_cycle(0, 4, 1, 1, 4'd1, 0, 0, 0, 0);
        rd_c(4);
        step_cycle(0, 0, 0, 0, 0, 1, 7, 8'hFE, 0);
        step_cycle(0, 7, 1, 1, 4'd3, 0, 0, 0, 0);
        rd_c(7);
        step_cycle(0, 3, 1, 1, 4'hE, 1, 3, 8'h40, 0);
        rd_c(3);
        step_cycle(0, 0, 0, 0, 0, 1, 0, 8'h55, 0);
        step_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < N + 1; i++)
            step_cycle(0, 5'($urandom), 1, 1, 4'($urandom), 1, 5'($urandom), 8'($urandom), i == 4);
        rd_c(0);
        step_cycle(0, 0, 0, 0, 0, 1, 2, 8'h77, 1);
        repeat (10) step_cycle(0, 5'($urandom), 1, 1, 4'd5, 1, 5'($urandom), 8'($urandom), 0);
        step_cycle(1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) rd_c(5'(i));
        for (int i = 0; i < 3000; i++)
            step_cycle($urandom_range(0, 299) == 0, 5'($urandom), $urandom_range(0, 3) != 0,
                       1'($urandom), 4'($urandom), $urandom_range(0, 3) == 0, 5'($urandom),
                       8'($urandom), $urandom_range(0, 79) == 0);
        repeat (3) step_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge Clk);
        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
